txt_term: RTL and testbench

Character-stream writer for the 40x24 text page that the video pipeline scans. It accepts bytes over a valid/ready handshake and handles cursor motion, line wrap, scroll and clear. It stores characters in an internal 1 KiB text RAM laid out in the Apple II $400 interleave. It also serves the text-to-pixel renderer's linear character fetch (index 0..959) through an independent read port, so it sits on the other end of that renderer's text-fetch interface.

---
 rtl/txt_term.sv | 232 +++++++++++++++++++++++
 tb/tb_txt_term.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txt_term.sv
// 40x24 text-page writer: byte stream in, cursor/wrap/scroll/clear handling,
// Apple II interleaved 1 KiB text RAM with an independent renderer read port.
`timescale 1ns/1ps
module txt_term #(
    parameter int         COLS      = 40,
    parameter int         ROWS      = 24,
    parameter logic [7:0] CLEAR_CHR = 8'hA0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  chr_d,
    input  logic        chr_valid,
    output logic        chr_ready,
    input  logic [15:0] vdp_adr,
    output logic [7:0]  vdp_q,
    output logic [5:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [5:0] LAST_COL   = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
    localparam logic [9:0] CELLS      = 10'(COLS * ROWS);
    localparam logic [9:0] COLS_10    = 10'(COLS);
    localparam logic [9:0] SCROLL_LEN = 10'(COLS * (ROWS - 1));

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [7:0]  mem_q [0:1023];
    logic [7:0]  srd_q;
    logic [7:0]  vdp_q_q;

    logic        accept_s;
    logic        printable_s;
    logic        is_ff_s;
    logic        adv_s;
    logic        we_s;
    logic [9:0]  wa_s;
    logic [7:0]  wd_s;
    logic [9:0]  sra_s;
    logic        vdp_oob_s;
    logic [9:0]  vdp_ra_s;

    // Interleaved address: 128*(row%8) + 40*(row/8) + col.
    function automatic logic [9:0] rc2int(input logic [4:0] row, input logic [5:0] col);
        logic [9:0] hi;
        hi = {8'd0, row[4:3]};
        return {row[2:0], 7'd0} + (hi << 5) + (hi << 3) + {4'd0, col};
    endfunction

    // Linear index (< 960) to interleaved; row = (lin/8)*205 >> 10 is exact here.
    function automatic logic [9:0] lin2int(input logic [9:0] lin);
        logic [14:0] q;
        logic [14:0] prod;
        logic [4:0]  row;
        logic [9:0]  row40;
        logic [9:0]  col;
        q     = {8'd0, lin[9:3]};
        prod  = (q << 7) + (q << 6) + (q << 3) + (q << 2) + q;
        row   = prod[14:10];
        row40 = ({5'd0, row} << 5) + ({5'd0, row} << 3);
        col   = lin - row40;
        return rc2int(row, col[5:0]);
    endfunction

    assign chr_ready   = (state_q == ST_IDLE) && !reset;
    assign accept_s    = chr_valid && chr_ready;
    assign printable_s = (chr_d[6:5] != 2'b00);
    assign is_ff_s     = (chr_d[6:0] == 7'h0C);
    assign vdp_oob_s   = (vdp_adr >= {6'd0, CELLS});
    assign vdp_ra_s    = lin2int(vdp_adr[9:0]);

    // Decode whether the incoming byte causes a line advance.
    always_comb begin
        adv_s = 1'b0;
        case (chr_d[6:0])
            7'h0D, 7'h0A: adv_s = 1'b1;
            default:      adv_s = printable_s && (x_q == LAST_COL);
        endcase
    end

    // Next-state, cursor and RAM write-port control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        we_s    = 1'b0;
        wa_s    = 10'd0;
        wd_s    = CLEAR_CHR;
        sra_s   = 10'd0;
        case (state_q)
            ST_CLEAR: begin
                we_s = 1'b1;
                wa_s = lin2int(cnt_q);
                x_d  = 6'd0;
                y_d  = 5'd0;
                if (cnt_q == CELLS - 10'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    case (chr_d[6:0])
                        7'h0D: x_d = 6'd0;
                        7'h0A: x_d = x_q;
                        7'h08: begin
                            if (x_q != 6'd0) begin
                                x_d = x_q - 6'd1;
                            end else begin
                                x_d = x_q;
                            end
                        end
                        7'h0C: begin
                            x_d     = 6'd0;
                            state_d = ST_CLEAR;
                            cnt_d   = 10'd0;
                        end
                        default: begin
                            if (printable_s) begin
                                we_s = 1'b1;
                                wa_s = rc2int(y_q, x_q);
                                wd_s = {1'b1, chr_d[6:0]};
                                x_d  = (x_q == LAST_COL) ? 6'd0 : x_q + 6'd1;
                            end else begin
                                x_d = x_q;
                            end
                        end
                    endcase
                    // The final printable write at (39,23) lands before the copy starts.
                    if (is_ff_s) begin
                        y_d = 5'd0;
                    end else if (adv_s && (y_q == LAST_ROW)) begin
                        y_d     = y_q;
                        state_d = ST_SCROLL;
                        cnt_d   = 10'd0;
                    end else if (adv_s) begin
                        y_d = y_q + 5'd1;
                    end else begin
                        y_d = y_q;
                    end
                end else begin
                    x_d = x_q;
                end
            end
            ST_SCROLL: begin
                if (cnt_q < SCROLL_LEN) begin
                    sra_s = lin2int(cnt_q + COLS_10);
                end else begin
                    sra_s = 10'd0;
                end
                if (cnt_q != 10'd0) begin
                    we_s = 1'b1;
                    wa_s = lin2int(cnt_q - 10'd1);
                    wd_s = srd_q;
                end else begin
                    we_s = 1'b0;
                end
                if (cnt_q == SCROLL_LEN) begin
                    state_d = ST_BLANK;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_BLANK: begin
                we_s = 1'b1;
                wa_s = lin2int(cnt_q + SCROLL_LEN);
                if (cnt_q == COLS_10 - 10'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = 10'd0;
            end
        endcase
    end

    // Control state, sequence counter and cursor registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 10'd0;
            x_q     <= 6'd0;
            y_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Text RAM write port and scroll-copy read port.
    always_ff @(posedge CLOCK_50) begin
        if (we_s && !reset) begin
            mem_q[wa_s] <= wd_s;
        end
        srd_q <= mem_q[sra_s];
    end

    // Renderer read port; same-cycle write to the same cell returns the old byte.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vdp_q_q <= 8'h00;
        end else begin
            vdp_q_q <= vdp_oob_s ? CLEAR_CHR : mem_q[vdp_ra_s];
        end
    end

    assign vdp_q = vdp_q_q;
    assign cur_x = x_q;
    assign cur_y = y_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_txt_term.sv
// Self-checking bench for txt_term: linear reference page model, renderer reads
// checked through an expected/observed scoreboard.
`timescale 1ns/1ps
module tb_txt_term;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  chr_d;
    logic        chr_valid;
    logic        chr_ready;
    logic [15:0] vdp_adr;
    logic [7:0]  vdp_q;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ref_mem [0:959];
    int         ref_x;
    int         ref_y;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         adr_q [$];

    txt_term dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .chr_d     (chr_d),
        .chr_valid (chr_valid),
        .chr_ready (chr_ready),
        .vdp_adr   (vdp_adr),
        .vdp_q     (vdp_q),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_rd(input int a);
        return (a >= 960) ? 8'hA0 : ref_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 960; i++) ref_mem[i] = 8'hA0;
        ref_x = 0;
        ref_y = 0;
    endtask

    task automatic model_advance();
        if (ref_y < 23) begin
            ref_y = ref_y + 1;
        end else begin
            for (int k = 0; k < 920; k++) ref_mem[k] = ref_mem[k + 40];
            for (int k = 920; k < 960; k++) ref_mem[k] = 8'hA0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [6:0] c;
        c = b[6:0];
        if (c == 7'h0D) begin
            ref_x = 0;
            model_advance();
        end else if (c == 7'h0A) begin
            model_advance();
        end else if (c == 7'h08) begin
            if (ref_x > 0) ref_x = ref_x - 1;
        end else if (c == 7'h0C) begin
            model_clear();
        end else if (c >= 7'h20) begin
            ref_mem[ref_y * 40 + ref_x] = {1'b1, c};
            if (ref_x == 39) begin
                ref_x = 0;
                model_advance();
            end else begin
                ref_x = ref_x + 1;
            end
        end
    endtask

    // Offer one byte, wait (bounded) for acceptance, update the model.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        chr_d     = b;
        chr_valid = 1'b1;
        while (!chr_ready && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        n_vec++;
        if (!chr_ready) begin
            n_err++;
            $display("FAIL accept_timeout byte=%h ready=%b required=1", b, chr_ready);
            chr_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            chr_valid = 1'b0;
            model_byte(b);
        end
    endtask

    task automatic count_low(output int lows);
        lows = 0;
        while (!chr_ready && lows < 3000) begin
            @(posedge clk); #1;
            lows++;
        end
    endtask

    // Drive renderer addresses lo..hi, pushing model expectations and DUT results.
    task automatic sweep(input int lo, input int hi);
        vdp_adr = 16'(lo);
        exp_q.push_back(model_rd(lo));
        adr_q.push_back(lo);
        for (int a = lo + 1; a <= hi + 1; a++) begin
            @(posedge clk); #1;
            got_q.push_back(vdp_q);
            if (a <= hi) begin
                vdp_adr = 16'(a);
                exp_q.push_back(model_rd(a));
                adr_q.push_back(a);
            end
        end
    endtask

    task automatic test_reset();
        int lows;
        logic [7:0] e, g;
        int a;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || chr_ready !== 1'b0 || cur_x !== 6'd0 || cur_y !== 5'd0 || vdp_q !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values busy=%b ready=%b x=%0d y=%0d q=%h required 1 0 0 0 00",
                     busy, chr_ready, cur_x, cur_y, vdp_q);
        end
        count_low(lows);
        n_vec++;
        if (lows != 960) begin
            n_err++;
            $display("FAIL clear_length got=%0d required=960", lows);
        end
        model_clear();
        sweep(0, 959);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL reset_fill adr=%0d got=%h required=%h", a, g, e);
            end
        end
        n_vec++;
        if (cur_x !== 6'd0 || cur_y !== 5'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cursor x=%0d y=%0d busy=%b required 0 0 0", cur_x, cur_y, busy);
        end
    endtask

    task automatic test_cr();
        logic [7:0] e, g;
        int a;
        send_byte(8'h41);
        n_vec++;
        if (cur_x !== 6'd1 || cur_y !== 5'd0) begin
            n_err++;
            $display("FAIL print_cursor x=%0d y=%0d required 1 0", cur_x, cur_y);
        end
        send_byte(8'h0D);
        n_vec++;
        if (cur_x !== 6'(ref_x) || cur_y !== 5'(ref_y) || ref_y != 1) begin
            n_err++;
            $display("FAIL cr_cursor x=%0d y=%0d required 0 1", cur_x, cur_y);
        end
        n_vec++;
        if (dut.mem_q[0] !== 8'hC1 || dut.mem_q[128] !== 8'hA0) begin
            n_err++;
            $display("FAIL interleave_row1 mem0=%h mem128=%h required C1 A0", dut.mem_q[0], dut.mem_q[128]);
        end
        send_byte(8'h58);
        n_vec++;
        if (dut.mem_q[128] !== 8'hD8) begin
            n_err++;
            $display("FAIL interleave_128 got=%h required=D8", dut.mem_q[128]);
        end
        sweep(0, 41);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cr_read adr=%0d got=%h required=%h", a, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        logic [7:0] e, g;
        int a;
        send_byte(8'h0C);
        count_low(lows);
        n_vec++;
        if (lows != 960) begin
            n_err++;
            $display("FAIL ff_clear_length got=%0d required=960", lows);
        end
        chr_d     = 8'h42;
        chr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n_vec++;
            if (chr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready idx=%0d got=%b required=1", i, chr_ready);
            end
            @(posedge clk); #1;
            model_byte(8'h42);
        end
        chr_valid = 1'b0;
        n_vec++;
        if (cur_x !== 6'd0 || cur_y !== 5'd1) begin
            n_err++;
            $display("FAIL b2b_cursor x=%0d y=%0d required 0 1", cur_x, cur_y);
        end
        sweep(0, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL b2b_read adr=%0d got=%h required=%h", a, g, e);
            end
        end
    endtask

    task automatic test_scroll();
        int lows;
        logic [7:0] e, g;
        int a;
        for (int i = 0; i < 40; i++) send_byte(8'h52);
        for (int i = 0; i < 21; i++) send_byte(8'h0A);
        for (int i = 0; i < 39; i++) send_byte(8'h20);
        n_vec++;
        if (cur_x !== 6'd39 || cur_y !== 5'd23) begin
            n_err++;
            $display("FAIL pre_scroll_cursor x=%0d y=%0d required 39 23", cur_x, cur_y);
        end
        send_byte(8'h5A);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL scroll_busy got=%b required=1", busy);
        end
        count_low(lows);
        n_vec++;
        if (lows != 961) begin
            n_err++;
            $display("FAIL scroll_length got=%0d required=961", lows);
        end
        n_vec++;
        if (cur_x !== 6'(ref_x) || cur_y !== 5'(ref_y) || ref_y != 23) begin
            n_err++;
            $display("FAIL scroll_cursor x=%0d y=%0d required 0 23", cur_x, cur_y);
        end
        n_vec++;
        if (dut.mem_q[976] !== 8'hA0 || dut.mem_q[40] !== 8'hA0) begin
            n_err++;
            $display("FAIL scroll_interleave mem976=%h mem40=%h required A0 A0", dut.mem_q[976], dut.mem_q[40]);
        end
        sweep(0, 959);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL scroll_read adr=%0d got=%h required=%h", a, g, e);
            end
        end
    endtask

    task automatic test_cursor_only();
        logic [7:0] e, g;
        int a;
        send_byte(8'h0C);
        for (int i = 0; i < 5; i++) send_byte(8'h0A);
        send_byte(8'h08);
        n_vec++;
        if (cur_x !== 6'd0 || cur_y !== 5'd5) begin
            n_err++;
            $display("FAIL bs_at_col0 x=%0d y=%0d required 0 5", cur_x, cur_y);
        end
        send_byte(8'hC1);
        send_byte(8'h08);
        n_vec++;
        if (cur_x !== 6'd0 || cur_y !== 5'd5) begin
            n_err++;
            $display("FAIL bs_step x=%0d y=%0d required 0 5", cur_x, cur_y);
        end
        for (int i = 0; i < 2; i++) send_byte(8'h0A);
        for (int i = 0; i < 7; i++) send_byte(8'h2E);
        n_vec++;
        if (cur_x !== 6'd7 || cur_y !== 5'd7) begin
            n_err++;
            $display("FAIL dots_cursor x=%0d y=%0d required 7 7", cur_x, cur_y);
        end
        send_byte(8'h0A);
        n_vec++;
        if (cur_x !== 6'd7 || cur_y !== 5'd8) begin
            n_err++;
            $display("FAIL lf_cursor x=%0d y=%0d required 7 8", cur_x, cur_y);
        end
        send_byte(8'h01);
        n_vec++;
        if (cur_x !== 6'd7 || cur_y !== 5'd8 || chr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ctrl_ignored x=%0d y=%0d ready=%b required 7 8 1", cur_x, cur_y, chr_ready);
        end
        send_byte(8'h8D);
        n_vec++;
        if (cur_x !== 6'(ref_x) || cur_y !== 5'(ref_y) || ref_y != 9) begin
            n_err++;
            $display("FAIL cr_highbit x=%0d y=%0d required 0 9", cur_x, cur_y);
        end
        sweep(199, 201);
        sweep(279, 288);
        sweep(960, 960);
        sweep(1000, 1000);
        sweep(65535, 65535);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL cursor_read adr=%0d got=%h required=%h", a, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_scroll();
        int lows;
        logic [7:0] e, g;
        int a;
        for (int i = 0; i < 20; i++) send_byte(8'h41);
        for (int i = 0; i < 14; i++) send_byte(8'h0A);
        send_byte(8'h0A);
        repeat (299) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || chr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_scroll_busy busy=%b ready=%b required 1 0", busy, chr_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        count_low(lows);
        n_vec++;
        if (lows != 960) begin
            n_err++;
            $display("FAIL abort_clear_length got=%0d required=960", lows);
        end
        model_clear();
        n_vec++;
        if (cur_x !== 6'd0 || cur_y !== 5'd0) begin
            n_err++;
            $display("FAIL abort_cursor x=%0d y=%0d required 0 0", cur_x, cur_y);
        end
        sweep(0, 959);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); a = adr_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL abort_fill adr=%0d got=%h required=%h", a, g, e);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        chr_d     = 8'h00;
        chr_valid = 1'b0;
        vdp_adr   = 16'd0;
        ref_x     = 0;
        ref_y     = 0;
        test_reset();
        test_cr();
        test_back_to_back();
        test_scroll();
        test_cursor_only();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
